// File: rtl/seq_scan_pkg.sv
// Shared types and helpers for the serial pattern-scan controller.
package seq_scan_pkg;

  localparam int unsigned SAT_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                              input logic [SAT_W-1:0] max_val);
    return (val >= max_val) ? val : val + SAT_W'(1);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial detector: history shift register, valid-bit counter and
// comparison against the programmed pattern.
module seq_match_core
  import seq_scan_pkg::*;
#(
  parameter int unsigned PLEN = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            shift_en,
  input  logic            bit_in,
  input  logic [PLEN-1:0] pattern,
  output logic            match_c,
  output logic            match_pulse
);

  localparam int unsigned VCW = $clog2(PLEN + 1);

  logic [PLEN-1:0] r_hist;
  logic [PLEN-1:0] w_hist_next;
  logic [VCW-1:0]  r_vcnt;
  logic [VCW-1:0]  w_vcnt_next;
  logic            r_match_pulse;

  // Match is judged on the post-shift history; valid count saturates at PLEN.
  always_comb begin
    w_hist_next = PLEN'({r_hist, bit_in});
    w_vcnt_next = (r_vcnt == VCW'(PLEN)) ? r_vcnt : r_vcnt + VCW'(1);
    match_c     = shift_en && (w_vcnt_next == VCW'(PLEN)) && (w_hist_next == pattern);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist        <= '0;
      r_vcnt        <= '0;
      r_match_pulse <= 1'b0;
    end else if (clear) begin
      r_hist        <= '0;
      r_vcnt        <= '0;
      r_match_pulse <= 1'b0;
    end else begin
      r_match_pulse <= match_c;
      if (shift_en) begin
        r_hist <= w_hist_next;
        r_vcnt <= w_vcnt_next;
      end
    end
  end

  assign match_pulse = r_match_pulse;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Start/busy/done sequencer feeding a parallel word MSB-first into the
// serial matcher. Optional first-match position: SEQ_SCAN_FIRST_POS_EN.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PLEN  = 4,
  parameter int unsigned CNTW  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       din,
  input  logic                   cfg_load,
  input  logic [PLEN-1:0]        cfg_pattern,
  output logic                   busy,
  output logic                   done,
  output logic                   match_pulse,
  output logic [CNTW-1:0]        match_cnt
`ifdef SEQ_SCAN_FIRST_POS_EN
  ,
  output logic [$clog2(WIDTH):0] first_pos
`endif
);

  localparam int unsigned BCW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_idle;
  logic            w_accept;
  logic            w_shift_en;
  logic            w_match;
  logic [WIDTH-1:0] r_shift;
  logic [BCW-1:0]  r_bitcnt;
  logic [PLEN-1:0] r_pattern;
  logic [CNTW-1:0] r_match_cnt;
  logic            r_busy;
  logic            r_done;

  // Next-state decode; the unused encoding behaves as IDLE.
  always_comb begin
    w_state_next = S_IDLE;
    w_idle       = 1'b0;
    w_accept     = 1'b0;
    w_shift_en   = 1'b0;
    case (r_state)
      S_SHIFT: begin
        w_shift_en   = 1'b1;
        w_state_next = (r_bitcnt == BCW'(WIDTH - 1)) ? S_DONE : S_SHIFT;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: begin
        w_idle = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_SHIFT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_pattern   <= '0;
      r_match_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_busy <= (w_state_next == S_SHIFT) || (w_state_next == S_DONE);
      r_done <= (w_state_next == S_DONE);
      if (w_idle && cfg_load) r_pattern <= cfg_pattern;
      if (w_accept) begin
        r_shift     <= din;
        r_bitcnt    <= '0;
        r_match_cnt <= '0;
      end else if (w_shift_en) begin
        r_shift  <= r_shift << 1;
        r_bitcnt <= r_bitcnt + BCW'(1);
        if (w_match) r_match_cnt <= CNTW'(sat_inc(SAT_W'(r_match_cnt), SAT_W'(CNT_MAX)));
      end
    end
  end

  seq_match_core #(
    .PLEN (PLEN)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .clear       (w_accept),
    .shift_en    (w_shift_en),
    .bit_in      (r_shift[WIDTH-1]),
    .pattern     (r_pattern),
    .match_c     (w_match),
    .match_pulse (match_pulse)
  );

`ifdef SEQ_SCAN_FIRST_POS_EN
  localparam int unsigned FPW = $clog2(WIDTH) + 1;
  logic [FPW-1:0] r_first_pos;

  // Index is >= PLEN >= 2, so zero doubles as "no match yet".
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         r_first_pos <= '0;
    else if (w_accept)                                 r_first_pos <= '0;
    else if (w_shift_en && w_match && r_first_pos == '0) r_first_pos <= FPW'(r_bitcnt) + FPW'(1);
  end

  assign first_pos = r_first_pos;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign match_cnt = r_match_cnt;

endmodule
